rf_wb_ctrl: RTL and testbench

Writeback controller for the core's single-write-port, two-read-port, 32×32 register file. Arbitrates three writeback sources (debug, load/store unit, ALU) onto the one write port, drops writes to x0, and keeps a per-register busy scoreboard so the issue stage stalls on pending load results. Sits between the execute/memory stages and the register file's `rfwr`/`rfrd`/`rfD` inputs.

---
 rtl/rf_wb_pkg.sv | 8 +
 rtl/rf_wb_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/rf_wb_ctrl.sv | 75 +++++++
 tb/tb_rf_wb_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback controller.
package rf_wb_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {SRC_NONE, SRC_DBG, SRC_LSU, SRC_ALU} wb_src_t;
endpackage

// File: rtl/rf_wb_if.sv
// Writeback sources, issue-stage hazard query and register-file write port.
interface rf_wb_if;
  import rf_wb_pkg::*;

  logic            dbg_valid, dbg_ready;
  logic [AW-1:0]   dbg_rd;
  logic [XLEN-1:0] dbg_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            iss_valid, iss_load, iss_stall;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
  logic            rfwr;
  logic [AW-1:0]   rfrd;
  logic [XLEN-1:0] rfD;

  modport master (
    output dbg_valid, dbg_rd, dbg_data, lsu_valid, lsu_rd, lsu_data,
           alu_valid, alu_rd, alu_data, iss_valid, iss_load, iss_rs1, iss_rs2, iss_rd,
    input  dbg_ready, lsu_ready, alu_ready, iss_stall, rfwr, rfrd, rfD
  );

  modport slave (
    input  dbg_valid, dbg_rd, dbg_data, lsu_valid, lsu_rd, lsu_data,
           alu_valid, alu_rd, alu_data, iss_valid, iss_load, iss_rs1, iss_rs2, iss_rd,
    output dbg_ready, lsu_ready, alu_ready, iss_stall, rfwr, rfrd, rfD
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-load scoreboard; stalls issue on RAW/WAW against loads.
module rf_scoreboard
  import rf_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic          iss_load,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  output logic          iss_stall
);
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            set_en;

  assign iss_stall = !rst && iss_valid &&
                     (busy_reg[iss_rs1] || busy_reg[iss_rs2] || busy_reg[iss_rd]);
  assign set_en    = iss_valid && !iss_stall && iss_load && (iss_rd != '0);

  assign busy_next[0] = 1'b0;

  // A new load to the same register outranks the returning load's clear.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] = (set_en && (iss_rd == AW'(gi))) ? 1'b1 :
                             (clr_en && (clr_rd == AW'(gi))) ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback arbiter (debug > round-robin LSU/ALU) driving the registered RF write port.
module rf_wb_ctrl
  import rf_wb_pkg::*;
(
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave bus
);
  wb_src_t         sel;
  logic            rr_reg;        // 0: LSU preferred, 1: ALU preferred
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            rfwr_reg;
  logic [AW-1:0]   rfrd_reg;
  logic [XLEN-1:0] rfd_reg;

  always_comb begin
    sel = SRC_NONE;
    if (rst)                              sel = SRC_NONE;
    else if (bus.dbg_valid)               sel = SRC_DBG;
    else if (bus.lsu_valid && bus.alu_valid) sel = rr_reg ? SRC_ALU : SRC_LSU;
    else if (bus.lsu_valid)               sel = SRC_LSU;
    else if (bus.alu_valid)               sel = SRC_ALU;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (sel)
      SRC_DBG: begin sel_rd = bus.dbg_rd; sel_data = bus.dbg_data; end
      SRC_LSU: begin sel_rd = bus.lsu_rd; sel_data = bus.lsu_data; end
      SRC_ALU: begin sel_rd = bus.alu_rd; sel_data = bus.alu_data; end
      default: begin sel_rd = '0;         sel_data = '0;           end
    endcase
  end

  assign bus.dbg_ready = (sel == SRC_DBG);
  assign bus.lsu_ready = (sel == SRC_LSU);
  assign bus.alu_ready = (sel == SRC_ALU);

  // Writes to x0 complete the handshake but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg   <= 1'b0;
      rfwr_reg <= 1'b0;
      rfrd_reg <= '0;
      rfd_reg  <= '0;
    end else begin
      rfwr_reg <= (sel != SRC_NONE) && (sel_rd != '0);
      if ((sel != SRC_NONE) && (sel_rd != '0)) begin
        rfrd_reg <= sel_rd;
        rfd_reg  <= sel_data;
      end
      if (sel == SRC_LSU)      rr_reg <= 1'b1;
      else if (sel == SRC_ALU) rr_reg <= 1'b0;
    end
  end

  assign bus.rfwr = rfwr_reg;
  assign bus.rfrd = rfrd_reg;
  assign bus.rfD  = rfd_reg;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_load  (bus.iss_load),
    .iss_rs1   (bus.iss_rs1),
    .iss_rs2   (bus.iss_rs2),
    .iss_rd    (bus.iss_rd),
    .clr_en    (sel == SRC_LSU),
    .clr_rd    (bus.lsu_rd),
    .iss_stall (bus.iss_stall)
  );
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed and random checks of rf_wb_ctrl against a behavioural writeback/scoreboard model.
module tb_rf_wb_ctrl;
  import rf_wb_pkg::*;

  logic clk;
  logic rst;
  rf_wb_if bus ();

  rf_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending loads as a flag per register, preferred source as a name-like int
  bit m_busy [NREG];
  int m_pref;          // 0 = LSU next on contention, 1 = ALU
  int last_grant;      // 0 none, 1 dbg, 2 lsu, 3 alu
  int lsu_rdy_cnt;
  int alu_rdy_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_pref     = 0;
    last_grant = 0;
  endtask

  task automatic idle();
    bus.dbg_valid = 0; bus.lsu_valid = 0; bus.alu_valid = 0; bus.iss_valid = 0;
    bus.iss_load  = 0;
  endtask

  // One clock: called just after a posedge with inputs already driven.
  task automatic cycle(input string tag);
    int g;
    bit st;
    bit wr;
    logic [AW-1:0] w_rd;
    logic [XLEN-1:0] w_d;
    #4;
    if (bus.dbg_valid) g = 1;
    else if (bus.lsu_valid && bus.alu_valid) g = (m_pref == 0) ? 2 : 3;
    else if (bus.lsu_valid) g = 2;
    else if (bus.alu_valid) g = 3;
    else g = 0;
    st = bus.iss_valid && (m_busy[bus.iss_rs1] || m_busy[bus.iss_rs2] || m_busy[bus.iss_rd]);
    check({tag, "_dbg_ready"}, 32'(bus.dbg_ready), 32'(g == 1));
    check({tag, "_lsu_ready"}, 32'(bus.lsu_ready), 32'(g == 2));
    check({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'(g == 3));
    check({tag, "_stall"}, 32'(bus.iss_stall), 32'(st));
    if (bus.lsu_ready) lsu_rdy_cnt++;
    if (bus.alu_ready) alu_rdy_cnt++;
    w_rd = (g == 1) ? bus.dbg_rd : (g == 2) ? bus.lsu_rd : bus.alu_rd;
    w_d  = (g == 1) ? bus.dbg_data : (g == 2) ? bus.lsu_data : bus.alu_data;
    wr   = (g != 0) && (w_rd != 0);
    if (g == 2 && bus.lsu_rd != 0) m_busy[bus.lsu_rd] = 1'b0;
    if (bus.iss_valid && !st && bus.iss_load && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
    if (g == 2) m_pref = 1;
    if (g == 3) m_pref = 0;
    last_grant = g;
    @(posedge clk);
    #1;
    check({tag, "_rfwr"}, 32'(bus.rfwr), 32'(wr));
    if (wr) begin
      check({tag, "_rfrd"}, 32'(bus.rfrd), 32'(w_rd));
      check({tag, "_rfD"}, bus.rfD, w_d);
    end
    $display("[%0t] %s grant=%0d wr=%0d rd=%0d data=%h stall=%0d", $time, tag, g, wr, w_rd, w_d, st);
  endtask

  initial begin
    int lsu0, alu0;
    rst = 1'b1;
    idle();
    bus.dbg_rd = 0; bus.dbg_data = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.alu_rd = 0; bus.alu_data = 0;
    bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0;
    lsu_rdy_cnt = 0; alu_rdy_cnt = 0;
    model_reset();

    // Reset: readies and stall held low even with everything requesting
    bus.dbg_valid = 1; bus.lsu_valid = 1; bus.alu_valid = 1; bus.iss_valid = 1;
    #2;
    check("rst_dbg_ready", 32'(bus.dbg_ready), 0);
    check("rst_lsu_ready", 32'(bus.lsu_ready), 0);
    check("rst_alu_ready", 32'(bus.alu_ready), 0);
    check("rst_stall", 32'(bus.iss_stall), 0);
    @(posedge clk); #1;
    check("rst_rfwr", 32'(bus.rfwr), 0);
    check("rst_rfrd", 32'(bus.rfrd), 0);
    check("rst_rfD", bus.rfD, 0);
    idle();
    rst = 1'b0;
    cycle("idle");

    // Contention: LSU first (rr at reset), then ALU
    bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'h11;
    bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h22;
    cycle("cont1");
    check("cont1_first_is_lsu", 32'(bus.rfrd), 3);
    bus.lsu_valid = 0;
    cycle("cont2");
    bus.alu_valid = 0;
    check("cont2_second_is_alu", 32'(bus.rfrd), 4);

    // Debug overtakes both; LSU/ALU order still alternates afterwards
    bus.dbg_valid = 1; bus.dbg_rd = 7; bus.dbg_data = 32'h77;
    bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'h33;
    bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h44;
    cycle("dbg1");
    bus.dbg_valid = 0;
    cycle("dbg2");
    if (last_grant == 2) bus.lsu_valid = 0; else bus.alu_valid = 0;
    cycle("dbg3");
    idle();
    cycle("dbg4");

    // x0 drop
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF_FFFF;
    cycle("x0");
    bus.alu_valid = 0;
    cycle("x0_after");

    // Load hazard on r8
    bus.iss_valid = 1; bus.iss_load = 1; bus.iss_rd = 8; bus.iss_rs1 = 1; bus.iss_rs2 = 2;
    cycle("ld8_issue");
    bus.iss_load = 0; bus.iss_rd = 10; bus.iss_rs1 = 8;
    cycle("ld8_stall1");
    cycle("ld8_stall2");
    bus.lsu_valid = 1; bus.lsu_rd = 8; bus.lsu_data = 32'h1234;
    cycle("ld8_return");
    check("ld8_written", bus.rfD, 32'h1234);
    bus.lsu_valid = 0;
    cycle("ld8_release");

    // Set/clear collision on r9: new load wins
    bus.iss_load = 1; bus.iss_rd = 9; bus.iss_rs1 = 1; bus.iss_rs2 = 2;
    bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h99;
    cycle("col_edge");
    bus.lsu_valid = 0; bus.iss_load = 0; bus.iss_rd = 11; bus.iss_rs1 = 9;
    cycle("col_still_busy");
    check("col_stall_dut", 32'(bus.iss_stall), 1);
    bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h999;
    cycle("col_clear");
    idle();
    cycle("col_done");

    // Fairness: both continuously valid for 10 cycles
    lsu0 = lsu_rdy_cnt; alu0 = alu_rdy_cnt;
    bus.lsu_valid = 1; bus.lsu_rd = 20; bus.alu_valid = 1; bus.alu_rd = 21;
    for (int i = 0; i < 10; i++) begin
      bus.lsu_data = $urandom; bus.alu_data = $urandom;
      cycle("fair");
    end
    check("fair_lsu_grants", 32'(lsu_rdy_cnt - lsu0), 5);
    check("fair_alu_grants", 32'(alu_rdy_cnt - alu0), 5);
    idle();
    cycle("fair_done");

    // Reset mid-write: ALU grant to r5 discarded, pending load to r12 forgotten
    bus.iss_valid = 1; bus.iss_load = 1; bus.iss_rd = 12; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    cycle("ld12_issue");
    bus.iss_valid = 0; bus.iss_load = 0;
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEAD_BEEF;
    #4;
    check("mid_alu_ready_pre", 32'(bus.alu_ready), 1);
    #1 rst = 1'b1;
    #1;
    check("mid_alu_ready_rst", 32'(bus.alu_ready), 0);
    bus.iss_valid = 1; bus.iss_rs1 = 12; bus.iss_rd = 13;
    #1;
    check("mid_stall_rst", 32'(bus.iss_stall), 0);
    @(posedge clk); #1;
    check("mid_rfwr", 32'(bus.rfwr), 0);
    check("mid_rfrd", 32'(bus.rfrd), 0);
    check("mid_rfD", bus.rfD, 0);
    rst = 1'b0;
    bus.alu_valid = 0;
    model_reset();
    cycle("post_rst");
    idle();

    // Random traffic obeying hold-until-ready
    for (int i = 0; i < 400; i++) begin
      if (!bus.dbg_valid && $urandom_range(0, 7) == 0) begin
        bus.dbg_valid = 1; bus.dbg_rd = 5'($urandom_range(0, 15)); bus.dbg_data = $urandom;
      end
      if (!bus.lsu_valid && $urandom_range(0, 1) == 0) begin
        bus.lsu_valid = 1; bus.lsu_rd = 5'($urandom_range(0, 15)); bus.lsu_data = $urandom;
      end
      if (!bus.alu_valid && $urandom_range(0, 1) == 0) begin
        bus.alu_valid = 1; bus.alu_rd = 5'($urandom_range(0, 15)); bus.alu_data = $urandom;
      end
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_load  = 1'($urandom_range(0, 1));
      bus.iss_rs1   = 5'($urandom_range(0, 15));
      bus.iss_rs2   = 5'($urandom_range(0, 15));
      bus.iss_rd    = 5'($urandom_range(0, 15));
      cycle("rand");
      if (last_grant == 1) bus.dbg_valid = 0;
      if (last_grant == 2) bus.lsu_valid = 0;
      if (last_grant == 3) bus.alu_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
